sdram_arbiter: RTL and testbench

Two-port arbiter that shares the single command interface of `SDRAMController` between two requesters, A and B. A typical pairing is a pixel-capture writer on A and a readout engine on B. Grants use round-robin with a bounded burst lock. Accepted read commands are tagged in an in-order FIFO, so returning `cmdReadData` is steered back to the requester that issued it. The block sits between the requesters and `SDRAMController` in the top level, clocked on the controller's `clk`.

---
 rtl/sdram_arbiter.sv | 145 ++++++++++++++
 tb/tb_sdram_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// Shares one SDRAMController command port between requesters A and B using round-robin
// grants with a burst cap; an in-order tag FIFO steers returning read data to its issuer.
module sdram_arbiter #(
  parameter int AddrWidth = 25,
  parameter int DataWidth = 16,
  parameter int MaxBurst  = 16,
  parameter int ReadDepth = 8
) (
  input  logic                 clk,
  input  logic                 rst_,
  input  logic                 a_cmdTrigger,
  input  logic [AddrWidth-1:0] a_cmdAddr,
  input  logic                 a_cmdWrite,
  input  logic [DataWidth-1:0] a_cmdWriteData,
  output logic                 a_cmdReady,
  output logic [DataWidth-1:0] a_cmdReadData,
  output logic                 a_cmdReadDataValid,
  input  logic                 b_cmdTrigger,
  input  logic [AddrWidth-1:0] b_cmdAddr,
  input  logic                 b_cmdWrite,
  input  logic [DataWidth-1:0] b_cmdWriteData,
  output logic                 b_cmdReady,
  output logic [DataWidth-1:0] b_cmdReadData,
  output logic                 b_cmdReadDataValid,
  output logic                 ram_cmdTrigger,
  output logic [AddrWidth-1:0] ram_cmdAddr,
  output logic                 ram_cmdWrite,
  output logic [DataWidth-1:0] ram_cmdWriteData,
  input  logic                 ram_cmdReady,
  input  logic [DataWidth-1:0] ram_cmdReadData,
  input  logic                 ram_cmdReadDataValid,
  output logic                 err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GNT_A = 2'd1;
  localparam logic [1:0] GNT_B = 2'd2;

  localparam int PtrW   = (ReadDepth > 1) ? $clog2(ReadDepth) : 1;
  localparam int CntW   = PtrW + 1;
  localparam int BurstW = $clog2(MaxBurst + 1);

  logic [1:0]             state_q, state_d;
  logic [BurstW-1:0]      burst_q, burst_d;
  logic [(1<<PtrW)-1:0]   tag_q;
  logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   err_q;

  logic gnt_a, gnt_b, sel_trig, sel_write;
  logic fifo_full, fifo_empty, rd_block;
  logic accept, push, pop, head_tag, burst_done;

  assign gnt_a      = (state_q == GNT_A);
  assign gnt_b      = (state_q == GNT_B);
  assign sel_trig   = (gnt_a & a_cmdTrigger) | (gnt_b & b_cmdTrigger);
  assign sel_write  = (gnt_a & a_cmdWrite) | (gnt_b & b_cmdWrite);
  assign fifo_full  = (cnt_q == CntW'(ReadDepth));
  assign fifo_empty = (cnt_q == '0);

  // A read with nowhere to park its tag is held off; writes never need a tag.
  assign rd_block = (gnt_a | gnt_b) & ~sel_write & fifo_full;

  assign ram_cmdTrigger   = sel_trig & ~rd_block;
  assign ram_cmdWrite     = sel_write;
  assign ram_cmdAddr      = gnt_a ? a_cmdAddr : (gnt_b ? b_cmdAddr : '0);
  assign ram_cmdWriteData = gnt_a ? a_cmdWriteData : (gnt_b ? b_cmdWriteData : '0);

  assign a_cmdReady = ram_cmdReady & gnt_a & ~rd_block;
  assign b_cmdReady = ram_cmdReady & gnt_b & ~rd_block;

  assign accept     = ram_cmdTrigger & ram_cmdReady;
  assign push       = accept & ~sel_write;
  assign pop        = ram_cmdReadDataValid & ~fifo_empty;
  assign head_tag   = tag_q[rd_ptr_q];
  assign burst_done = accept & (burst_q >= BurstW'(MaxBurst - 1));

  assign a_cmdReadData      = ram_cmdReadData;
  assign b_cmdReadData      = ram_cmdReadData;
  assign a_cmdReadDataValid = pop & ~head_tag;
  assign b_cmdReadDataValid = pop & head_tag;
  assign err                = err_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (a_cmdTrigger)      state_d = GNT_A;
        else if (b_cmdTrigger) state_d = GNT_B;
      end
      GNT_A: begin
        if (!a_cmdTrigger)                   state_d = b_cmdTrigger ? GNT_B : IDLE;
        else if (burst_done && b_cmdTrigger) state_d = GNT_B;
      end
      GNT_B: begin
        if (!b_cmdTrigger)                   state_d = a_cmdTrigger ? GNT_A : IDLE;
        else if (burst_done && a_cmdTrigger) state_d = GNT_A;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    burst_d = burst_q;
    if (state_d != state_q)
      burst_d = '0;
    else if (accept && (burst_q != BurstW'(MaxBurst)))
      burst_d = burst_q + BurstW'(1);
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q  <= IDLE;
      burst_q  <= '0;
      tag_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      cnt_q   <= cnt_d;
      if (push) begin
        tag_q[wr_ptr_q] <= gnt_b;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop)
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      // Data arriving with no tag outstanding has no owner: drop it and flag.
      if (ram_cmdReadDataValid && fifo_empty)
        err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Randomized and directed bench for sdram_arbiter, checked every cycle against a
// transaction-level model (holder, run length, queue of read owners).
module tb_sdram_arbiter;
  localparam int AW   = 25;
  localparam int DW   = 16;
  localparam int MAXB = 4;
  localparam int RD   = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_;
  logic [1:0]    req_trig, req_wr;
  logic [AW-1:0] req_addr [2];
  logic [DW-1:0] req_wdat [2];
  logic          ram_rdy, ram_rv;
  logic [DW-1:0] ram_rdata;

  logic          a_rdy, a_vld, b_rdy, b_vld, ram_trig, ram_wr, err;
  logic [DW-1:0] a_rdat, b_rdat, ram_wdat;
  logic [AW-1:0] ram_addr;

  sdram_arbiter #(.AddrWidth(AW), .DataWidth(DW), .MaxBurst(MAXB), .ReadDepth(RD)) dut (
    .clk(clk), .rst_(rst_),
    .a_cmdTrigger(req_trig[0]), .a_cmdAddr(req_addr[0]), .a_cmdWrite(req_wr[0]),
    .a_cmdWriteData(req_wdat[0]), .a_cmdReady(a_rdy), .a_cmdReadData(a_rdat),
    .a_cmdReadDataValid(a_vld),
    .b_cmdTrigger(req_trig[1]), .b_cmdAddr(req_addr[1]), .b_cmdWrite(req_wr[1]),
    .b_cmdWriteData(req_wdat[1]), .b_cmdReady(b_rdy), .b_cmdReadData(b_rdat),
    .b_cmdReadDataValid(b_vld),
    .ram_cmdTrigger(ram_trig), .ram_cmdAddr(ram_addr), .ram_cmdWrite(ram_wr),
    .ram_cmdWriteData(ram_wdat), .ram_cmdReady(ram_rdy), .ram_cmdReadData(ram_rdata),
    .ram_cmdReadDataValid(ram_rv), .err(err)
  );

  int n_chk = 0;
  int n_fail = 0;

  int owner;
  int run;
  int tagq[$];
  bit err_m;
  bit last_acc[2];
  int acc_who;
  int acc_cnt[2];
  logic obs_trig, obs_ardy, obs_avld, obs_bvld, obs_err;
  logic [DW-1:0] obs_adat, obs_bdat;
  int p_on[2], p_wr[2], p_rdy, p_rv;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    owner = -1;
    run = 0;
    tagq.delete();
    err_m = 1'b0;
    last_acc[0] = 1'b0;
    last_acc[1] = 1'b0;
    acc_who = -1;
    acc_cnt[0] = 0;
    acc_cnt[1] = 0;
  endtask

  // One clock: compare at negedge, advance model, return just after posedge.
  task automatic step();
    int h, n;
    bit hb, blk, etrig, acc, ewr;
    logic [AW-1:0] eaddr;
    logic [DW-1:0] ewdat;
    @(negedge clk);
    h = owner;
    hb = h[0];
    blk   = (h >= 0) && !req_wr[hb] && (tagq.size() == RD);
    etrig = (h >= 0) && req_trig[hb] && !blk;
    ewr   = (h >= 0) && req_wr[hb];
    eaddr = (h >= 0) ? req_addr[hb] : '0;
    ewdat = (h >= 0) ? req_wdat[hb] : '0;
    check_eq("ram_trig", ram_trig, etrig);
    check_eq("ram_addr", ram_addr, eaddr);
    check_eq("ram_wr", ram_wr, ewr);
    check_eq("ram_wdat", ram_wdat, ewdat);
    check_eq("a_rdy", a_rdy, ram_rdy && (h == 0) && !blk);
    check_eq("b_rdy", b_rdy, ram_rdy && (h == 1) && !blk);
    check_eq("a_vld", a_vld, ram_rv && (tagq.size() > 0) && (tagq[0] == 0));
    check_eq("b_vld", b_vld, ram_rv && (tagq.size() > 0) && (tagq[0] == 1));
    check_eq("a_rdat", a_rdat, ram_rdata);
    check_eq("b_rdat", b_rdat, ram_rdata);
    check_eq("err", err, err_m);
    obs_trig = ram_trig; obs_ardy = a_rdy; obs_avld = a_vld; obs_bvld = b_vld;
    obs_err = err; obs_adat = a_rdat; obs_bdat = b_rdat;

    acc = etrig && ram_rdy;
    last_acc[0] = 1'b0;
    last_acc[1] = 1'b0;
    acc_who = -1;
    if (acc) begin
      last_acc[hb] = 1'b1;
      acc_who = h;
      acc_cnt[hb]++;
    end
    if (ram_rv) begin
      if (tagq.size() > 0) void'(tagq.pop_front());
      else err_m = 1'b1;
    end
    if (acc && !req_wr[hb]) tagq.push_back(h);

    n = h;
    if (h < 0) begin
      if (req_trig[0]) n = 0;
      else if (req_trig[1]) n = 1;
    end else if (!req_trig[hb]) begin
      n = req_trig[~hb] ? 1 - h : -1;
    end else if (acc && (run + 1 >= MAXB) && req_trig[~hb]) begin
      n = 1 - h;
    end
    if (n != h) run = 0;
    else if (acc && run < MAXB) run++;
    owner = n;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs();
    for (int x = 0; x < 2; x++) begin
      if (!req_trig[x] || last_acc[x]) begin
        if ($urandom_range(99) < p_on[x]) begin
          req_trig[x] = 1'b1;
          req_wr[x]   = ($urandom_range(99) < p_wr[x]);
          req_addr[x] = AW'($urandom);
          req_wdat[x] = DW'($urandom);
        end else begin
          req_trig[x] = 1'b0;
        end
      end
    end
    ram_rdy   = ($urandom_range(99) < p_rdy);
    ram_rv    = (tagq.size() > 0) && ($urandom_range(99) < p_rv);
    ram_rdata = DW'($urandom);
  endtask

  task automatic wait_acc(input int x, input string tag);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      got = last_acc[x];
    end
    check_eq(tag, got, 1);
  endtask

  task automatic do_reset();
    rst_ = 1'b0;
    req_trig = 2'b11;
    req_wr = 2'b00;
    ram_rdy = 1'b1;
    ram_rv = 1'b1;
    ram_rdata = 16'h5a5a;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ram_trig", ram_trig, 0);
    check_eq("rst_a_rdy", a_rdy, 0);
    check_eq("rst_b_rdy", b_rdy, 0);
    check_eq("rst_a_vld", a_vld, 0);
    check_eq("rst_b_vld", b_vld, 0);
    check_eq("rst_err", err, 0);
    req_trig = 2'b00;
    ram_rv = 1'b0;
    @(posedge clk);
    #2;
    rst_ = 1'b1;
  endtask

  task automatic set_req(input int x, input bit wr, input logic [AW-1:0] addr);
    req_trig[x] = 1'b1;
    req_wr[x]   = wr;
    req_addr[x] = addr;
    req_wdat[x] = DW'(addr);
  endtask

  initial begin
    rst_ = 1'b0;
    req_trig = '0;
    req_wr = '0;
    for (int x = 0; x < 2; x++) begin
      req_addr[x] = '0;
      req_wdat[x] = '0;
    end

    // A alone, back-to-back writes.
    do_reset();
    p_on[0] = 100; p_on[1] = 0; p_wr[0] = 100; p_wr[1] = 100; p_rdy = 100; p_rv = 0;
    for (int i = 0; i < 21; i++) begin
      rand_inputs();
      step();
      if (i > 0) check_eq("t1_a_rdy", obs_ardy, 1);
    end
    check_eq("t1_a_count", acc_cnt[0], 20);
    check_eq("t1_b_count", acc_cnt[1], 0);

    // Both from IDLE: A first, then groups of MAXB with no gap.
    do_reset();
    p_on[0] = 100; p_on[1] = 100;
    rand_inputs();
    step();
    check_eq("t2_idle_cycle", acc_who, -1);
    for (int i = 0; i < 16; i++) begin
      rand_inputs();
      step();
      check_eq("t2_burst_seq", acc_who, (i / MAXB) % 2);
    end

    // Interleaved reads A0, B0, A1 with returns steered by issue order.
    do_reset();
    ram_rdy = 1'b1; ram_rv = 1'b0;
    set_req(0, 1'b0, 25'h10); wait_acc(0, "t3_acc_a0");
    req_trig[0] = 1'b0;
    set_req(1, 1'b0, 25'h20); wait_acc(1, "t3_acc_b0");
    req_trig[1] = 1'b0;
    set_req(0, 1'b0, 25'h30); wait_acc(0, "t3_acc_a1");
    req_trig[0] = 1'b0;
    repeat (2) step();
    ram_rv = 1'b1; ram_rdata = 16'h1111; step();
    check_eq("t3_r0_avld", obs_avld, 1); check_eq("t3_r0_bvld", obs_bvld, 0);
    check_eq("t3_r0_data", obs_adat, 16'h1111);
    ram_rdata = 16'h2222; step();
    check_eq("t3_r1_avld", obs_avld, 0); check_eq("t3_r1_bvld", obs_bvld, 1);
    check_eq("t3_r1_data", obs_bdat, 16'h2222);
    ram_rdata = 16'h3333; step();
    check_eq("t3_r2_avld", obs_avld, 1); check_eq("t3_r2_bvld", obs_bvld, 0);
    check_eq("t3_r2_data", obs_adat, 16'h3333);
    ram_rv = 1'b0; step();
    check_eq("t3_no_err", obs_err, 0);

    // Tag FIFO full: reads stall, writes pass, one return releases the read.
    do_reset();
    ram_rdy = 1'b1; ram_rv = 1'b0;
    for (int i = 0; i < RD; i++) begin
      set_req(0, 1'b0, AW'(32'h100 + i));
      wait_acc(0, "t4_fill");
    end
    set_req(0, 1'b1, 25'h200); wait_acc(0, "t4_write_while_full");
    set_req(0, 1'b0, 25'h300);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("t4_blk_trig", obs_trig, 0);
      check_eq("t4_blk_ardy", obs_ardy, 0);
    end
    ram_rv = 1'b1; ram_rdata = 16'hbeef; step();
    check_eq("t4_ret_avld", obs_avld, 1);
    check_eq("t4_still_blk", last_acc[0], 0);
    ram_rv = 1'b0; step();
    check_eq("t4_released", last_acc[0], 1);

    // Read data with no outstanding tag.
    do_reset();
    req_trig = 2'b00; ram_rv = 1'b0; step();
    check_eq("t5_err_before", obs_err, 0);
    ram_rv = 1'b1; ram_rdata = 16'hdead; step();
    check_eq("t5_avld", obs_avld, 0); check_eq("t5_bvld", obs_bvld, 0);
    ram_rv = 1'b0; step();
    check_eq("t5_err_set", obs_err, 1);
    repeat (3) step();
    check_eq("t5_err_sticky", obs_err, 1);

    // Asynchronous reset mid-burst with reads outstanding.
    do_reset();
    ram_rdy = 1'b1; ram_rv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_req(0, 1'b0, AW'(32'h400 + i));
      wait_acc(0, "t6_read");
    end
    set_req(0, 1'b1, 25'h500); wait_acc(0, "t6_write");
    #1 rst_ = 1'b0;
    #1 check_eq("t6_async_trig", ram_trig, 0);
    check_eq("t6_async_ardy", a_rdy, 0);
    model_reset();
    @(posedge clk);
    #2 rst_ = 1'b1;
    step();
    check_eq("t6_idle_after", obs_trig, 0);
    step();
    check_eq("t6_regrant", last_acc[0], 1);
    req_trig[0] = 1'b0;
    ram_rv = 1'b1; step();
    check_eq("t6_stale_avld", obs_avld, 0); check_eq("t6_stale_bvld", obs_bvld, 0);
    ram_rv = 1'b0; step();
    check_eq("t6_stale_err", obs_err, 1);

    // Randomized traffic under shifting load profiles.
    do_reset();
    for (int blk = 0; blk < 15; blk++) begin
      p_on[0] = $urandom_range(100); p_on[1] = $urandom_range(100);
      p_wr[0] = $urandom_range(80, 20); p_wr[1] = $urandom_range(80, 20);
      p_rdy = $urandom_range(100, 30); p_rv = $urandom_range(90, 10);
      repeat (200) begin
        rand_inputs();
        step();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
